// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO front end: register offsets, STATUS bit positions and
// the default window base address.
package mmio_pkg;

  localparam logic [31:0] DEF_MMIO_BASE = 32'h1000;

  localparam int unsigned OFF_SENSOR = 0;
  localparam int unsigned OFF_TURN   = 1;
  localparam int unsigned OFF_OUT0   = 2;

  localparam int unsigned CHG_BIT  = 0;
  localparam int unsigned PEND_BIT = 1;

  function automatic int unsigned OFF_STATUS(input int unsigned num_out);
    return OFF_OUT0 + num_out;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser plus stability counter for the sensor board; the change pulse is
// high in the cycle whose edge updates the stable value.
module sensor_debounce #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] stable,
  output logic              chg_pulse
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [DATA_W-1:0] sync1_q, sync2_q, cand_q, cand_d, stable_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Acceptance looks at the next-state counter so a held change lands 2+DEB_CYCLES edges
  // after it is first sampled.
  assign chg_pulse = (cnt_d == CNT_MAX) && (cand_d != stable_q);
  assign stable    = stable_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      if (chg_pulse) stable_q <= cand_d;
    end
  end

endmodule

// File: rtl/mmio_map_ctrl.sv
// MMIO front end: decodes SENSOR/TURN/OUT/STATUS words and routes all other addresses to RAM.
// Define MMIO_IRQ_EN to add the IEN register and the registered irq output.
module mmio_map_ctrl
  import mmio_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RAM_AW = 12,
  parameter logic [ADDR_W-1:0] MMIO_BASE = ADDR_W'(DEF_MMIO_BASE),
  parameter int unsigned NUM_OUT = 3,
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      wEn,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         dataIn,
  output logic [DATA_W-1:0]         dataOut,
  output logic [NUM_OUT*DATA_W-1:0] out_regs,
  input  logic [DATA_W-1:0]         sensor_in,
  input  logic [DATA_W-1:0]         turn_in,
  input  logic                      turn_wEn,
  output logic                      turn_pending,
`ifdef MMIO_IRQ_EN
  output logic                      irq,
`endif
  output logic                      ram_wEn,
  output logic [RAM_AW-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_din,
  input  logic [DATA_W-1:0]         ram_dout
);

  localparam int unsigned OFF_W = 4;
`ifdef MMIO_IRQ_EN
  localparam int unsigned OFF_IEN  = OFF_STATUS(NUM_OUT) + 1;
  localparam int unsigned LAST_OFF = OFF_IEN;
`else
  localparam int unsigned LAST_OFF = OFF_STATUS(NUM_OUT);
`endif

  logic [ADDR_W-1:0] off_full;
  logic [OFF_W-1:0]  off, out_idx;
  logic              hit, mmio_we, wr_turn, wr_status, wr_out;
  logic [DATA_W-1:0] sensor_val, status_w, rd_d, rd_q, turn_q;
  logic [DATA_W-1:0] out_q [NUM_OUT];
  logic              chg_set, chg_q, pend_q, ram_sel_q;
`ifdef MMIO_IRQ_EN
  logic [1:0]        ien_q;
  logic              irq_q, wr_ien;
`endif

  // Offset is taken modulo the full address width, so addresses below the base never hit.
  always_comb begin
    off_full = addr - MMIO_BASE;
    hit      = (addr >= MMIO_BASE) && (off_full <= ADDR_W'(LAST_OFF));
    off      = off_full[OFF_W-1:0];
    out_idx  = off - OFF_W'(OFF_OUT0);
  end

  assign mmio_we   = wEn & hit;
  assign wr_turn   = mmio_we && (off == OFF_W'(OFF_TURN));
  assign wr_status = mmio_we && (off == OFF_W'(OFF_STATUS(NUM_OUT)));
  assign wr_out    = mmio_we && (off >= OFF_W'(OFF_OUT0)) && (out_idx < OFF_W'(NUM_OUT));
`ifdef MMIO_IRQ_EN
  assign wr_ien    = mmio_we && (off == OFF_W'(OFF_IEN));
`endif

  assign ram_wEn  = wEn & ~hit;
  assign ram_addr = addr[RAM_AW-1:0];
  assign ram_din  = dataIn;

  sensor_debounce #(
    .DATA_W     (DATA_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .clock     (clock),
    .reset     (reset),
    .din       (sensor_in),
    .stable    (sensor_val),
    .chg_pulse (chg_set)
  );

  always_comb begin
    status_w           = '0;
    status_w[CHG_BIT]  = chg_q;
    status_w[PEND_BIT] = pend_q;
  end

  always_comb begin
    rd_d = '0;
    if (hit) begin
      if (off == OFF_W'(OFF_SENSOR))               rd_d = sensor_val;
      else if (off == OFF_W'(OFF_TURN))            rd_d = turn_q;
      else if (off == OFF_W'(OFF_STATUS(NUM_OUT))) rd_d = status_w;
`ifdef MMIO_IRQ_EN
      else if (off == OFF_W'(OFF_IEN))             rd_d = DATA_W'(ien_q);
`endif
      for (int i = 0; i < NUM_OUT; i++) begin
        if (off == OFF_W'(OFF_OUT0 + i)) rd_d = out_q[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q      <= '0;
      ram_sel_q <= 1'b0;
      turn_q    <= '0;
      pend_q    <= 1'b0;
      chg_q     <= 1'b0;
      for (int i = 0; i < NUM_OUT; i++) out_q[i] <= '0;
`ifdef MMIO_IRQ_EN
      ien_q     <= '0;
      irq_q     <= 1'b0;
`endif
    end else begin
      rd_q      <= rd_d;
      ram_sel_q <= ~hit;
      // Engine write has priority; a simultaneous CPU write to TURN is dropped.
      if (turn_wEn) begin
        turn_q <= turn_in;
        pend_q <= 1'b1;
      end else if (wr_turn) begin
        turn_q <= dataIn;
        pend_q <= 1'b0;
      end
      if (chg_set) chg_q <= 1'b1;
      else if (wr_status && dataIn[CHG_BIT]) chg_q <= 1'b0;
      for (int i = 0; i < NUM_OUT; i++) begin
        if (wr_out && (out_idx == OFF_W'(i))) out_q[i] <= dataIn;
      end
`ifdef MMIO_IRQ_EN
      if (wr_ien) ien_q <= dataIn[1:0];
      irq_q <= (chg_q & ien_q[0]) | (pend_q & ien_q[1]);
`endif
    end
  end

  assign dataOut      = ram_sel_q ? ram_dout : rd_q;
  assign turn_pending = pend_q;
`ifdef MMIO_IRQ_EN
  assign irq          = irq_q;
`endif

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign out_regs[g*DATA_W +: DATA_W] = out_q[g];
  end

endmodule

// File: doc/mmio_map_ctrl.md
Name: mmio_map_ctrl

Overview:
- Parametrised memory-mapped I/O front end between the CPU data-memory port and the board peripherals.
- Decodes a window of MMIO registers: debounced sensor board, a computer-turn mailbox with a pending flag, NUM_OUT writable board registers, and a status register.
- Every address outside the window goes to an external synchronous RAM.
- Read data is registered, so MMIO reads and RAM reads have the same 1-cycle latency.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 32, CPU address width.
- RAM_AW, 12, RAM word-address width.
- MMIO_BASE, 32'h1000, first MMIO word address.
- NUM_OUT, 3, number of CPU-writable output registers (1..8).
- DEB_CYCLES, 4, consecutive synchronised samples required before a sensor change is accepted (>=1).

Ports:
- clock  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- wEn  in  1  CPU write strobe.
- addr  in  ADDR_W  CPU word address.
- dataIn  in  DATA_W  CPU write data.
- dataOut  out  DATA_W  read data, valid the cycle after addr is presented.
- out_regs  out  NUM_OUT*DATA_W  output registers; reg i at bits [i*DATA_W +: DATA_W].
- sensor_in  in  DATA_W  raw, asynchronous sensor board.
- turn_in  in  DATA_W  engine-side mailbox data.
- turn_wEn  in  1  engine-side mailbox write strobe.
- turn_pending  out  1  mailbox holds unread engine data.
- ram_wEn  out  1  RAM write enable.
- ram_addr  out  RAM_AW  RAM address, equal to addr[RAM_AW-1:0].
- ram_din  out  DATA_W  RAM write data, equal to dataIn.
- ram_dout  in  DATA_W  RAM read data, 1-cycle latency.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. On reset, every register, out_regs, dataOut, turn_pending, status and the debounce state go to 0.
- Address map, as word offsets from MMIO_BASE:
  - +0: SENSOR, read-only, debounced.
  - +1: TURN mailbox.
  - +2 .. +1+NUM_OUT: OUT[0..NUM_OUT-1].
  - +2+NUM_OUT: STATUS. Bit0 CHG is sticky and write-1-to-clear; bit1 is PEND (read-only); other bits read 0.
- Decode: an address is an MMIO hit when it lies in [MMIO_BASE, MMIO_BASE+NUM_OUT+2]; the compare uses the full ADDR_W.
- RAM path: ram_wEn = wEn & ~hit. An MMIO write never reaches the RAM.
- Reads: dataOut is registered.
  - Each cycle, the register captures the selected MMIO value when hit is set, otherwise it passes ram_dout through.
  - The hit/offset for that selection come from addr sampled in the previous cycle.
  - Reads have no side effects.
- Writes to SENSOR are ignored. Writes to the OUT registers take effect at the next edge.
- Sensor path:
  - 2-flop synchroniser feeds a candidate register and a counter.
  - When the synchronised value differs from the candidate: the candidate takes the new value and the counter is cleared.
  - Otherwise the counter increments, saturating at DEB_CYCLES-1.
  - When the counter equals DEB_CYCLES-1 and the candidate differs from SENSOR: SENSOR takes the candidate and CHG is set.
  - A held change therefore appears 2+DEB_CYCLES edges after it is first sampled.
  - Glitches shorter than DEB_CYCLES are discarded.
- CHG set and clear in the same cycle: the set wins.
- Mailbox:
  - turn_wEn loads turn_in and sets PEND.
  - A CPU write to TURN loads dataIn and clears PEND.
  - If both occur in the same cycle, the engine write wins, PEND=1 and the CPU write is dropped.
- turn_pending = PEND.
- Reset mid-operation: the debounce counter restarts, and a partially stable input must again satisfy the full DEB_CYCLES.

Optional Feature:
- Macro: MMIO_IRQ_EN.
- When defined:
  - An extra IEN register sits at offset +3+NUM_OUT; bits[1:0] are read/write and reset to 0.
  - An output port irq (1 bit) is added: irq = (CHG&IEN[0]) | (PEND&IEN[1]), registered, so it lags the flags by 1 cycle.
- When undefined:
  - There is no irq port and no IEN register.
  - Offset +3+NUM_OUT is an ordinary RAM address.

Decomposition:
- Shared package mmio_pkg holds:
  - Offset constants OFF_SENSOR, OFF_TURN, OFF_OUT0, and OFF_STATUS(NUM_OUT) as a function.
  - STATUS bit indices CHG_BIT=0 and PEND_BIT=1.
  - The default MMIO_BASE.
- One natural sub-module, sensor_debounce (params DATA_W, DEB_CYCLES), contains the synchroniser, candidate, counter, stable output and a 1-cycle change pulse.

Test Plan:
- Reset, then read every MMIO offset -> all read 0 one cycle after each address; ram_wEn stays 0.
- Write 32'hA5 to 0x1002 and 32'h5A to 0x0010 -> out_regs[31:0]=32'hA5 and ram_wEn pulses only for 0x0010; reading 0x0010 returns the RAM model value with 1-cycle latency.
- Set sensor_in=32'h1 and hold it -> SENSOR=1 and STATUS=1 exactly 6 edges later (DEB_CYCLES=4); then write 1 to STATUS -> STATUS=0.
- Pulse sensor_in to 32'h2 for 3 cycles, then return it to 32'h1 -> SENSOR stays 1 and CHG stays 0.
- turn_wEn with turn_in=32'h77 in the same cycle as a CPU write of 32'h11 to 0x1001 -> TURN=32'h77 and turn_pending=1; a later lone CPU write of 32'h11 -> TURN=32'h11 and turn_pending=0.
- With MMIO_IRQ_EN: write 2'b10 to IEN, then pulse turn_wEn -> irq=1 one cycle after PEND is set; a CPU write to TURN drops irq the cycle after PEND clears.
